shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter TOP_WIDTH, default 8, SHALL set the operand width W (W >= 2).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 multiplier  input  W  SHALL carry the unsigned multiplier operand.
REQ-005 multiplicand  input  W  SHALL carry the unsigned multiplicand operand.
REQ-006 start  input  1  SHALL request a new multiplication when high at a rising edge.
REQ-007 product  output  2W+1  SHALL carry the result, registered.
REQ-008 done  output  1  SHALL flag that product holds a valid completed result, registered.

Function
REQ-009 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-010 In IDLE or DONE, start high at an edge (E0) SHALL:
- latch both operands into internal registers;
- clear the accumulator and iteration counter;
- enter CALC;
- deassert done at that edge.
REQ-011 Operand inputs SHALL be ignored after E0 until the next accepted start.
REQ-012 Each CALC edge SHALL:
- examine the next latched multiplier bit, LSB first;
- add the multiplicand, shifted left by the bit index, to the accumulator when that bit is 1;
- advance the counter.
REQ-013 CALC SHALL run exactly W iterations (edges E1..EW); at EW the FSM SHALL enter DONE, done SHALL go high, and product SHALL equal the unsigned product.
REQ-014 Latency from the start-sampling edge to done high SHALL be W clock cycles (8 for W=8).
REQ-015 Arithmetic SHALL be unsigned and internal width SHALL prevent overflow; product[2W] SHALL always read 0 and product[2W-1:0] SHALL equal multiplier*multiplicand.
REQ-016 start high during CALC SHALL be ignored, with no restart and no operand reload.
REQ-017 In DONE, done SHALL stay high and product SHALL hold until the next accepted start or reset.
REQ-018 product SHALL hold its previous value while in CALC; it SHALL update only on entry to DONE.
REQ-019 Either or both operands zero SHALL yield product 0 with the same latency as any other operand pair.
REQ-020 start held high continuously SHALL cause back-to-back operations: start is re-accepted at the edge following entry to DONE, so done is high for exactly one cycle.

Reset
REQ-021 rst low SHALL immediately, without waiting for a clock edge, force state IDLE, product 0, done 0, and clear the counter, accumulator and operand registers.
REQ-022 rst asserted mid-CALC SHALL abort the operation; no done SHALL follow.
REQ-023 After rst is released, the block SHALL accept start at the first rising edge.

Configuration
REQ-024 Macro SHIFT_ADD_EARLY_EXIT_EN SHALL control early termination.
REQ-025 With SHIFT_ADD_EARLY_EXIT_EN defined, CALC SHALL enter DONE at the edge where no 1 bits remain in the unprocessed multiplier bits. Latency SHALL equal the index of the highest set multiplier bit plus 1, minimum 1 cycle when multiplier = 0. product SHALL equal the result given without the macro.
REQ-026 Without SHIFT_ADD_EARLY_EXIT_EN, latency SHALL always be W cycles (REQ-014).

Verification
REQ-027 rst low, then high; multiplier=0xE3, multiplicand=0xF2; start pulsed one cycle -> done high 8 cycles later; product=0x0D696 (54934); done and product held until the next start.
REQ-028 multiplier=0xFF, multiplicand=0xFF -> product=0x0FE01 (65025) and product[16]=0.
REQ-029 multiplier=0x00, multiplicand=0xA5 -> product=0.
- Latency 8 without the macro.
- Latency 1 with SHIFT_ADD_EARLY_EXIT_EN.
REQ-030 Start 0x03 x 0x05; at cycle 3, pulse start with 0x07 x 0x07 -> second start ignored; result 15 after 8 cycles.
REQ-031 Start 0x12 x 0x34; assert rst at cycle 4 -> done=0 and product=0 immediately. Then start 0x02 x 0x03 -> product=6.
REQ-032 start held high with 0x10 x 0x10 -> product=256; done high for one cycle per result; operations repeat every 9 cycles.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock, LSB first.
// Optional macro SHIFT_ADD_EARLY_EXIT_EN finishes as soon as no set multiplier bits remain.
//
// state | meaning
// IDLE  | waiting for start after reset, product/done cleared
// CALC  | one partial-product step per clock
// DONE  | product valid and held, done high, new start accepted
module shift_add_multiplier #(
    parameter int TOP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TOP_WIDTH-1:0] multiplier,
    input  logic [TOP_WIDTH-1:0] multiplicand,
    input  logic                 start,
    output logic [2*TOP_WIDTH:0] product,
    output logic                 done
);

    localparam int W  = TOP_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    mplier_q;
    logic [2*W-1:0]  mcand_q;
    logic [2*W-1:0]  acc_q;
    logic [2*W-1:0]  acc_sum;
    logic [CW-1:0]   cnt_q;
    logic            last_step;
    logic            load;
    logic            step;
    logic            finish;

    // The multiplier register shifts right each step, so bit 0 is always the next bit to examine
    // and the multiplicand register shifts left in step with it.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SHIFT_ADD_EARLY_EXIT_EN
    assign last_step = (mplier_q[W-1:1] == '0) || (cnt_q == CW'(W - 1));
`else
    assign last_step = (cnt_q == CW'(W - 1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (last_step) state_nx = DONE;
            DONE:    if (start) state_nx = CALC;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE, DONE: load = start;
            CALC: begin
                step   = 1'b1;
                finish = last_step;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            product  <= '0;
            done     <= 1'b0;
        end else if (load) begin
            mplier_q <= multiplier;
            mcand_q  <= {{W{1'b0}}, multiplicand};
            acc_q    <= '0;
            cnt_q    <= '0;
            done     <= 1'b0;
        end else if (step) begin
            acc_q    <= acc_sum;
            mplier_q <= mplier_q >> 1;
            mcand_q  <= mcand_q << 1;
            cnt_q    <= cnt_q + CW'(1);
            if (finish) begin
                product <= {1'b0, acc_sum};
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (W=8): directed cases plus random operands
// checked against a plain-arithmetic model of product and latency.
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   multiplier = '0;
    logic [W-1:0]   multiplicand = '0;
    logic           start = 1'b0;
    logic [2*W:0]   product;
    logic           done;

    int total  = 0;
    int passed = 0;
    logic [2*W:0] last_prod = '0;

    shift_add_multiplier #(.TOP_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .start        (start),
        .product      (product),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h (failures so far %0d)", tag, obs, exp, total - passed);
    endtask

    function automatic int ref_latency(input logic [W-1:0] a);
        int msb;
        msb = 0;
        for (int i = 0; i < W; i++) if (a[i]) msb = i;
`ifdef SHIFT_ADD_EARLY_EXIT_EN
        return msb + 1;
`else
        return (msb >= 0) ? W : W;
`endif
    endfunction

    function automatic logic [2*W:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W:0] wa, wb;
        wa = {{(W+1){1'b0}}, a};
        wb = {{(W+1){1'b0}}, b};
        return wa * wb;
    endfunction

    // Caller is positioned at a negedge (sync=0) or the task moves to the next one (sync=1).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sync);
        int cyc;
        logic [2*W:0] exp;
        exp = ref_product(a, b);
        if (sync) @(negedge clk);
        multiplier   = a;
        multiplicand = b;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplier   = W'($urandom);
        multiplicand = W'($urandom);
        check("done_cleared_at_start", done, 0);
        check("product_held_at_start", product, last_prod);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done !== 1'b1) check("product_held_in_calc", product, last_prod);
        end
        check("latency", cyc, ref_latency(a));
        check("product", product, exp);
        check("product_msb_zero", product[2*W], 0);
        last_prod = exp;
    endtask

    initial begin
        int cyc;
        int lat;
        int waits;

        // asynchronous reset with no clock edge needed
        #2 rst = 1'b0;
        #2;
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // start accepted on the very first edge after reset release
        run_op(8'hE3, 8'hF2, 0);
        check("basic_value", product, 17'h0D696);
        repeat (3) @(negedge clk);
        check("hold_done", done, 1);
        check("hold_product", product, 17'h0D696);

        run_op(8'hFF, 8'hFF, 1);
        check("max_value", product, 17'h0FE01);
        run_op(8'h00, 8'hA5, 1);
        check("zero_mplier", product, 0);
        run_op(8'hA5, 8'h00, 1);
        run_op(8'h00, 8'h00, 1);
        run_op(8'h80, 8'h01, 1);
        run_op(8'h01, 8'hFF, 1);

        // start during CALC must be ignored
        lat = ref_latency(8'h03);
        waits = (lat >= 3) ? 2 : lat - 1;
        @(negedge clk);
        multiplier = 8'h03; multiplicand = 8'h05; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        repeat (waits) begin @(negedge clk); cyc++; end
        multiplier = 8'h07; multiplicand = 8'h07; start = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        check("ignore_start_latency", cyc, lat);
        check("ignore_start_product", product, 15);
        @(negedge clk);
        check("ignore_start_no_restart", done, 1);
        last_prod = 15;

        // reset in the middle of a calculation
        @(negedge clk);
        multiplier = 8'h12; multiplicand = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        @(negedge clk);
        rst = 1'b1;
        last_prod = '0;
        cyc = 0;
        repeat (12) begin @(negedge clk); if (done === 1'b1) cyc++; end
        check("abort_no_done", cyc, 0);
        run_op(8'h02, 8'h03, 1);
        check("after_abort_value", product, 6);

        // start held high: back-to-back operations
        lat = ref_latency(8'h10);
        @(negedge clk);
        multiplier = 8'h10; multiplicand = 8'h10; start = 1'b1;
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < 40);
            check("b2b_period", cyc, lat + 1);
            check("b2b_product", product, 256);
            @(negedge clk);
            check("b2b_one_cycle_done", done, 0);
            cyc = 1;
        end
        start = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        check("b2b_final", product, 256);
        last_prod = 17'd256;

        // random operands against the model
        for (int n = 0; n < 25; n++) begin
            run_op(W'($urandom), W'($urandom), 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
